// File: rtl/counter_pkg.sv
// Shared constants and elaboration checks for the up/down modulus counter family.
package counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   // True when max_count is a usable top-of-range for a counter of the given width.
   function automatic bit max_count_ok(int width, int max_count);
      longint range_top;
      range_top = (longint'(1) << width) - 1;
      return (width >= 1) && (max_count >= 1) && (longint'(max_count) <= range_top);
   endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle between an up/down modulus counter and the logic driving it.
interface updown_mod_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             at_max;
   logic             at_zero;
   logic             wrap;

   modport master (
      output en, up_dn, load, load_val,
      input  count, at_max, at_zero, wrap
   );

   modport slave (
      input  en, up_dn, load, load_val,
      output count, at_max, at_zero, wrap
   );
endinterface

// File: rtl/updown_next_state.sv
// Next-state logic for the up/down modulus counter: load clamp, step, and
// end-of-range wrap or saturate.
module updown_next_state
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 2 ** WIDTH - 1,
   parameter int SATURATE  = MODE_WRAP
) (
   input  logic [WIDTH-1:0] count,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] next_count,
   output logic             next_wrap
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
   localparam logic             SAT   = (SATURATE == MODE_SAT);

   logic at_top;
   logic at_bottom;

   assign at_top    = (count == MAX_V);
   assign at_bottom = (count == '0);

   // The end-of-range compares pick the result, so the adder output is only
   // used when it cannot leave 0..MAX_COUNT.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      next_count = count;
      next_wrap  = 1'b0;
      if (load) begin
         next_count = (int'(load_val) > MAX_COUNT) ? MAX_V : load_val;
      end else if (en) begin
         if (up_dn == DIR_UP) begin
            if (at_top) begin
               next_wrap = 1'b1;
               if (!SAT) next_count = '0;
            end else begin
               next_count = count + WIDTH'(1);
            end
         end else begin
            if (at_bottom) begin
               next_wrap = 1'b1;
               if (!SAT) next_count = MAX_V;
            end else begin
               next_count = count - WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down counter with programmable modulus, parallel load, enable
// and wrap-or-saturate ends; holds only the registers and the end decodes.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MAX_COUNT = 2 ** WIDTH - 1,
   parameter int SATURATE  = MODE_WRAP
) (
   input  logic                clk,
   input  logic                rst,
   updown_mod_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

   if (!max_count_ok(WIDTH, MAX_COUNT)) begin : g_bad_max_count
      $error("updown_mod_counter: MAX_COUNT must lie in 1..2**WIDTH-1");
   end

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] next_count;
   logic             wrap_q;
   logic             next_wrap;

   updown_next_state #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .SATURATE  (SATURATE)
   ) u_next_state (
      .count      (count_q),
      .en         (bus.en),
      .up_dn      (bus.up_dn),
      .load       (bus.load),
      .load_val   (bus.load_val),
      .next_count (next_count),
      .next_wrap  (next_wrap)
   );

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= next_count;
         wrap_q  <= next_wrap;
      end
   end

   assign bus.count   = count_q;
   assign bus.wrap    = wrap_q;
   assign bus.at_max  = (count_q == MAX_V);
   assign bus.at_zero = (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: decade wrap, decade saturate and 8-bit wrap
// instances on one clock, checked against a queue of expected outputs.
module tb_updown_mod_counter;
   import counter_pkg::*;

   typedef struct packed {
      logic [7:0] cnt;
      logic       wrap;
      logic       amax;
      logic       azero;
   } obs_t;

   typedef struct {
      int en;
      int up;
      int ld;
      int lv;
      int cnt;
      int wrap;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   int maxv[3]  = '{9, 9, 255};
   int satv[3]  = '{0, 1, 0};
   int lvmax[3] = '{15, 15, 255};

   always #5 clk = ~clk;

   updown_mod_counter_if #(.WIDTH(4)) bus_a ();
   updown_mod_counter_if #(.WIDTH(4)) bus_b ();
   updown_mod_counter_if #(.WIDTH(8)) bus_c ();

   updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(MODE_WRAP)) u_dec_wrap (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(MODE_SAT)) u_dec_sat (
      .clk (clk), .rst (rst), .bus (bus_b.slave));
   updown_mod_counter #(.WIDTH(8), .SATURATE(MODE_WRAP)) u_byte (
      .clk (clk), .rst (rst), .bus (bus_c.slave));

   task automatic drive(int k, int e, int u, int l, int lv);
      case (k)
         0: begin
            bus_a.en = (e != 0); bus_a.up_dn = (u != 0);
            bus_a.load = (l != 0); bus_a.load_val = 4'(lv);
         end
         1: begin
            bus_b.en = (e != 0); bus_b.up_dn = (u != 0);
            bus_b.load = (l != 0); bus_b.load_val = 4'(lv);
         end
         default: begin
            bus_c.en = (e != 0); bus_c.up_dn = (u != 0);
            bus_c.load = (l != 0); bus_c.load_val = 8'(lv);
         end
      endcase
   endtask

   function automatic obs_t obs(int k);
      obs_t r;
      case (k)
         0:       r = '{8'(bus_a.count), bus_a.wrap, bus_a.at_max, bus_a.at_zero};
         1:       r = '{8'(bus_b.count), bus_b.wrap, bus_b.at_max, bus_b.at_zero};
         default: r = '{bus_c.count, bus_c.wrap, bus_c.at_max, bus_c.at_zero};
      endcase
      return r;
   endfunction

   function automatic obs_t mk(int c, int w, int mx);
      obs_t r;
      r.cnt   = 8'(c);
      r.wrap  = (w != 0);
      r.amax  = (c == mx);
      r.azero = (c == 0);
      return r;
   endfunction

   // Reference behaviour: take the unbounded step, then decide what leaving the range means.
   function automatic void model(int cur, int e, int u, int l, int lv, int mx, int s,
                                 output int nc, output int nw);
      int t;
      nc = cur;
      nw = 0;
      if (l != 0) begin
         nc = (lv > mx) ? mx : lv;
      end else if (e != 0) begin
         t = (u != 0) ? cur + 1 : cur - 1;
         if (t > mx || t < 0) begin
            nw = 1;
            nc = (s != 0) ? cur : ((t < 0) ? mx : 0);
         end else begin
            nc = t;
         end
      end
   endfunction

   task automatic test_reset();
      obs_t got, exp;
      for (int k = 0; k < 3; k++) drive(k, 1, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(mk(0, 0, maxv[k]));
         got = obs(k);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset[%0d]: got %p need %p", k, got, exp);
         end
      end
   endtask

   task automatic test_wrap_up();
      obs_t got, exp;
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 1, 0, 0);
      drive(1, 0, 1, 0, 0);
      drive(2, 0, 1, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         exp_q.push_back(mk(i % 10, (i == 10) ? 1 : 0, 9));
         @(posedge clk); #1;
         got = obs(0);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL wrap_up[%0d]: got %p need %p", i, got, exp);
         end
      end
   endtask

   task automatic test_down_wrap();
      step_t s[4] = '{'{0, 0, 1, 0, 0, 0}, '{1, 0, 0, 0, 9, 1},
                      '{1, 0, 0, 0, 8, 0}, '{1, 0, 0, 0, 7, 0}};
      obs_t got, exp;
      foreach (s[i]) begin
         @(negedge clk);
         drive(0, s[i].en, s[i].up, s[i].ld, s[i].lv);
         exp_q.push_back(mk(s[i].cnt, s[i].wrap, 9));
         @(posedge clk); #1;
         got = obs(0);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL down_wrap[%0d]: got %p need %p", i, got, exp);
         end
      end
   endtask

   task automatic test_saturate();
      step_t s[9] = '{'{0, 0, 1, 8, 8, 0}, '{1, 1, 0, 0, 9, 0}, '{1, 1, 0, 0, 9, 1},
                      '{1, 1, 0, 0, 9, 1}, '{0, 0, 1, 1, 1, 0}, '{1, 0, 0, 0, 0, 0},
                      '{1, 0, 0, 0, 0, 1}, '{1, 0, 0, 0, 0, 1}, '{0, 0, 0, 0, 0, 0}};
      obs_t got, exp;
      foreach (s[i]) begin
         @(negedge clk);
         drive(1, s[i].en, s[i].up, s[i].ld, s[i].lv);
         exp_q.push_back(mk(s[i].cnt, s[i].wrap, 9));
         @(posedge clk); #1;
         got = obs(1);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL saturate[%0d]: got %p need %p", i, got, exp);
         end
      end
   endtask

   task automatic test_load_clamp();
      step_t s[2] = '{'{0, 0, 1, 15, 9, 0}, '{1, 1, 1, 3, 3, 0}};
      obs_t got, exp;
      foreach (s[i]) begin
         @(negedge clk);
         drive(0, s[i].en, s[i].up, s[i].ld, s[i].lv);
         exp_q.push_back(mk(s[i].cnt, s[i].wrap, 9));
         @(posedge clk); #1;
         got = obs(0);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL load_clamp[%0d]: got %p need %p", i, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      obs_t got, exp;
      @(negedge clk);
      drive(0, 0, 0, 1, 6);
      drive(1, 1, 0, 0, 0);
      exp_q.push_back(mk(6, 0, 9));
      exp_q.push_back(mk(0, 1, 9));
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         got = obs(k);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL async_pre[%0d]: got %p need %p", k, got, exp);
         end
      end
      drive(0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(mk(0, 0, 9));
         got = obs(k);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL async_clear[%0d]: got %p need %p", k, got, exp);
         end
      end
      rst = 1'b0;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         drive(0, 1, 1, 0, 0);
         exp_q.push_back(mk(i, 0, 9));
         @(posedge clk); #1;
         got = obs(0);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL async_resume[%0d]: got %p need %p", i, got, exp);
         end
      end
   endtask

   task automatic test_full_width();
      step_t s[7] = '{'{0, 0, 1, 250, 250, 0}, '{1, 1, 0, 0, 251, 0}, '{1, 1, 0, 0, 252, 0},
                      '{1, 1, 0, 0, 253, 0}, '{1, 1, 0, 0, 254, 0}, '{1, 1, 0, 0, 255, 0},
                      '{1, 1, 0, 0, 0, 1}};
      obs_t got, exp;
      foreach (s[i]) begin
         @(negedge clk);
         drive(2, s[i].en, s[i].up, s[i].ld, s[i].lv);
         exp_q.push_back(mk(s[i].cnt, s[i].wrap, 255));
         @(posedge clk); #1;
         got = obs(2);
         exp = exp_q.pop_front();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL full_width[%0d]: got %p need %p", i, got, exp);
         end
      end
   endtask

   task automatic test_random();
      int   m_cnt[3];
      int   e, u, l, lv, nc, nw;
      obs_t got, exp;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         drive(k, 0, 0, 1, 0);
         m_cnt[k] = 0;
         exp_q.push_back(mk(0, 0, maxv[k]));
      end
      for (int n = 0; n <= 10000; n++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            got = obs(k);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL random[%0d] dut %0d: got %p need %p", n, k, got, exp);
            end
         end
         if (n == 10000) break;
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            e  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            u  = int'($urandom_range(0, 1));
            l  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            lv = int'($urandom_range(0, lvmax[k]));
            model(m_cnt[k], e, u, l, lv, maxv[k], satv[k], nc, nw);
            m_cnt[k] = nc;
            drive(k, e, u, l, lv);
            exp_q.push_back(mk(nc, nw, maxv[k]));
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) drive(k, 0, 0, 0, 0);
      test_reset();
      test_wrap_up();
      test_down_wrap();
      test_saturate();
      test_load_clamp();
      test_async_reset();
      test_full_width();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
